uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single uart_tx byte transmitter among NREQ independent byte sources, e.g. cursor/status reporter, key echo and heartbeat.
- Round-robin arbitration with a request/acknowledge handshake per source.
- Sequences the transmitter's send/busy handshake and optionally appends a CR LF terminator after a granted byte.
- Sits between the game-side reporters and uart_tx.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BUSY_TIMEOUT, 16, max cycles to wait for tx_busy to rise after tx_send before declaring a fault.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-source request level; held until ack
- req_data  in  8*NREQ  byte for source i at bits [8i+7:8i]; stable while req[i] high
- req_eol  in  NREQ  source i asks for CR (0x0D) then LF (0x0A) after its byte; sampled with grant
- ack  out  NREQ  one-cycle one-hot pulse: byte of source i latched
- tx_data  out  8  byte to uart_tx data_in
- tx_send  out  1  one-cycle send strobe to uart_tx
- tx_busy  in  1  uart_tx busy
- sched_busy  out  1  high whenever state != IDLE
- grant_idx  out  3  index of the most recent grant
- tx_fault  out  1  sticky; set on busy timeout, cleared only by reset

Behaviour:
- Reset (reset low, asynchronous): state IDLE, ack 0, tx_send 0, tx_data 0x00, sched_busy 0, grant_idx 0, tx_fault 0, rr pointer 0, eol flag 0. Takes effect immediately, even mid-byte. A uart_tx frame already started is not aborted by this block.
- All outputs are registered.
- States: IDLE, SEND, WAIT_HI, WAIT_LO, CR, LF.
- IDLE:
  - At an edge where |req and !tx_busy, grant the first requester with req set, searching from pointer upward mod NREQ.
  - Same edge: latch byte into tx_data, latch eol flag, pulse ack[g] (high exactly the following cycle), grant_idx<=g, pointer<=(g+1) mod NREQ, go to SEND.
  - If tx_busy is high (an external frame is in progress), stay in IDLE with no grant.
- SEND/CR/LF:
  - tx_send high for exactly one cycle; tx_data holds the byte (CR: 0x0D, LF: 0x0A). Go to WAIT_HI.
  - Timing: tx_send is high the cycle after the ack cycle, i.e. 2 cycles after the edge that samples req.
- WAIT_HI:
  - Wait for tx_busy=1, then go to WAIT_LO.
  - Counter reaching BUSY_TIMEOUT sets tx_fault and goes to WAIT_LO.
- WAIT_LO: on tx_busy=0, next state is:
  - CR if eol flag set and CR not yet sent;
  - LF after CR;
  - otherwise IDLE.
  - The eol flag clears on leaving LF.
- Requester contract:
  - After ack, req may drop. If req stays high the next cycle, it is treated as a new request and waits its round-robin turn.
  - A req that drops before ack is simply not served; there is no residue.
- Simultaneous requests: exactly one ack per granted byte. Other requests stay pending and see no ack until they are granted.
- No new grant is made while a CR/LF terminator is pending, so terminators are never interleaved with another source's byte.
- Throughput: at most one source byte per uart_tx frame plus 1 IDLE cycle.
- tx_data is not changed outside grant/CR/LF loading.

Test Plan:
- Reset release, req=001 data0=0x35, eol=0, tx_busy model 10 cycles -> ack=001 one cycle, tx_send 2 cycles after req sample with tx_data=0x35, sched_busy low after busy falls.
- req=111 held with data 0x41/0x42/0x43, each source drops req after its ack -> send order 0x41, 0x42, 0x43. Then raise req[0] and req[2] -> 0x41 before 0x43 (pointer wraps to 0).
- req[1] with eol=1, data 0x57 -> bytes 0x57, 0x0D, 0x0A back-to-back. req[0] raised during CR is served only after LF completes.
- tx_busy tied low -> tx_fault set BUSY_TIMEOUT cycles after tx_send; scheduler returns to IDLE and serves the next request.
- reset asserted during WAIT_LO with eol pending -> all outputs at reset values immediately. After release, no CR/LF is emitted and the pointer is 0.
- req[2] pulsed one cycle while tx_busy is high externally -> no ack, no tx_send.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte sources, with an optional CR LF terminator after a byte.
// Outputs are registered: ack one cycle after the req sample, tx_send one cycle later; no grant while tx_busy or a terminator is pending.
module uart_tx_scheduler #(
  parameter int NREQ         = 3,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_eol,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              sched_busy,
  output logic [2:0]        grant_idx,
  output logic              tx_fault
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, CR, LF} state_t;

  state_t          state, state_d;
  logic [2:0]      ptr, ptr_d, grant_d, gidx;
  logic            eol_flag, eol_d, cr_sent, cr_d, fault_d;
  logic            found, geol, tx_send_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NREQ-1:0] ack_d, gack;
  logic [7:0]      tx_data_d, gdata;

  // Rotating priority: first pass covers ptr..NREQ-1, second pass wraps to 0.
  always_comb begin
    found = 1'b0;
    gidx  = 3'd0;
    gdata = 8'h00;
    geol  = 1'b0;
    gack  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        gidx    = 3'(i);
        gdata   = req_data[8*i +: 8];
        geol    = req_eol[i];
        gack[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gidx    = 3'(i);
        gdata   = req_data[8*i +: 8];
        geol    = req_eol[i];
        gack[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    ack_d     = '0;
    tx_send_d = 1'b0;
    tx_data_d = tx_data;
    grant_d   = grant_idx;
    ptr_d     = ptr;
    eol_d     = eol_flag;
    cr_d      = cr_sent;
    cnt_d     = cnt;
    fault_d   = tx_fault;
    case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          tx_data_d = gdata;
          eol_d     = geol;
          cr_d      = 1'b0;
          ack_d     = gack;
          grant_d   = gidx;
          ptr_d     = (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;
          state_d   = SEND;
        end
      end
      SEND, CR, LF: begin
        tx_send_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_HI;
        if (state == LF) begin
          eol_d = 1'b0;
          cr_d  = 1'b0;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never acknowledged the strobe; flag it and move on
          fault_d = 1'b1;
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (eol_flag && !cr_sent) begin
            tx_data_d = 8'h0D;
            cr_d      = 1'b1;
            state_d   = CR;
          end else if (eol_flag) begin
            tx_data_d = 8'h0A;
            state_d   = LF;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ack        <= '0;
      tx_send    <= 1'b0;
      tx_data    <= 8'h00;
      sched_busy <= 1'b0;
      grant_idx  <= 3'd0;
      tx_fault   <= 1'b0;
      ptr        <= 3'd0;
      eol_flag   <= 1'b0;
      cr_sent    <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_d;
      ack        <= ack_d;
      tx_send    <= tx_send_d;
      tx_data    <= tx_data_d;
      sched_busy <= (state_d != IDLE);
      grant_idx  <= grant_d;
      tx_fault   <= fault_d;
      ptr        <= ptr_d;
      eol_flag   <= eol_d;
      cr_sent    <= cr_d;
      cnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized rounds against a queue-based round-robin model.
module tb_uart_tx_scheduler;
  localparam int NREQ = 3;
  localparam int BT   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_eol;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_busy;
  logic              sched_busy;
  logic [2:0]        grant_idx;
  logic              tx_fault;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_eol(req_eol),
    .ack(ack), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .sched_busy(sched_busy), .grant_idx(grant_idx), .tx_fault(tx_fault)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic ext_busy = 1'b0;
  logic model_en = 1'b1;
  int busy_len = 10;
  int busy_cnt = 0;
  int mptr = 0;

  logic [7:0] src_dat [NREQ][$];
  logic       src_eol [NREQ][$];
  logic [7:0] mq_dat  [NREQ][$];
  logic       mq_eol  [NREQ][$];
  logic [7:0] sent_q[$];
  int         send_cyc[$];
  int         ack_idx[$];
  logic [7:0] exp_q[$];
  int         exp_ack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample outputs, run the requesters and the uart_tx busy model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tx_send === 1'b1) begin
      sent_q.push_back(tx_data);
      send_cyc.push_back(cyc);
    end
    if (ack !== '0) begin
      check("ack_onehot", 32'($onehot(ack)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] === 1'b1) begin
          ack_idx.push_back(i);
          check("grant_idx", 32'(grant_idx), 32'(i));
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] === 1'b1 && req[i]) begin
        req[i] = 1'b0;
        if (src_dat[i].size() > 0) begin
          void'(src_dat[i].pop_front());
          void'(src_eol[i].pop_front());
        end
      end else if (!req[i] && src_dat[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = src_dat[i][0];
        req_eol[i] = src_eol[i][0];
      end
    end
    if (model_en && tx_send === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = ext_busy | (busy_cnt > 0);
  endtask

  task automatic src_push(input int i, input logic [7:0] d, input logic e);
    src_dat[i].push_back(d);
    src_eol[i].push_back(e);
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic e);
    src_push(i, d, e);
    mq_dat[i].push_back(d);
    mq_eol[i].push_back(e);
  endtask

  // Reference: all loaded sources stay pending, so the grant order is plain
  // round-robin over non-empty queues, each byte followed by CR LF if asked.
  task automatic model_run();
    while (1) begin
      int pick = -1;
      for (int off = 0; off < NREQ; off++) begin
        int i = (mptr + off) % NREQ;
        if (pick < 0 && mq_dat[i].size() > 0) pick = i;
      end
      if (pick < 0) break;
      exp_q.push_back(mq_dat[pick].pop_front());
      if (mq_eol[pick].pop_front()) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
      exp_ack.push_back(pick);
      mptr = (pick + 1) % NREQ;
    end
  endtask

  task automatic clear_logs();
    sent_q.delete(); send_cyc.delete(); ack_idx.delete();
    exp_q.delete(); exp_ack.delete();
  endtask

  function automatic bit all_idle();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (src_dat[i].size() > 0) e = 1'b0;
    return e && (req == '0) && (sched_busy === 1'b0) && (tx_busy === 1'b0);
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !all_idle()) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
    check({tag, "_acks"}, 32'(ack_idx.size()), 32'(exp_ack.size()));
    for (int i = 0; i < ack_idx.size() && i < exp_ack.size(); i++)
      check($sformatf("%s_ack%0d", tag, i), 32'(ack_idx[i]), 32'(exp_ack[i]));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
    check({tag, "_grant_idx"}, 32'(grant_idx), 32'd0);
    check({tag, "_tx_fault"}, 32'(tx_fault), 32'd0);
  endtask

  initial begin
    int n, s, na, ns;
    reset = 1'b0; req = '0; req_data = '0; req_eol = '0; tx_busy = 1'b0;
    repeat (2) step();
    check_reset_values("rst");
    reset = 1'b1; mptr = 0;

    // Single byte: ack one cycle after the sample, send one cycle after ack
    clear_logs(); busy_len = 10;
    load(0, 8'h35, 1'b0); model_run();
    step();
    step();
    check("t1_ack", 32'(ack), 32'b001);
    step();
    check("t1_ack_gone", 32'(ack), 32'd0);
    check("t1_send", 32'(tx_send), 32'd1);
    check("t1_data", 32'(tx_data), 32'h35);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin step(); n++; end
    while (tx_busy !== 1'b0 && n < 50) begin step(); n++; end
    check("t1_busy_timeout", 32'(n < 50), 32'd1);
    check("t1_sb_held", 32'(sched_busy), 32'd1);
    step();
    check("t1_sb_low", 32'(sched_busy), 32'd0);
    compare_stream("t1");

    // Three simultaneous sources, then 0 and 2 with the pointer wrapping
    reset = 1'b0; step(); reset = 1'b1; mptr = 0;
    clear_logs(); busy_len = 4;
    load(0, 8'h41, 1'b0); load(1, 8'h42, 1'b0); load(2, 8'h43, 1'b0);
    model_run(); drain("t2a", 400); compare_stream("t2a");
    clear_logs();
    load(0, 8'h41, 1'b0); load(2, 8'h43, 1'b0);
    model_run(); drain("t2b", 400); compare_stream("t2b");

    // Terminator: req[0] arriving during CR must follow LF
    clear_logs();
    src_push(1, 8'h57, 1'b1);
    n = 0;
    while (sent_q.size() < 2 && n < 200) begin step(); n++; end
    check("t3_cr_timeout", 32'(n < 200), 32'd1);
    src_push(0, 8'h60, 1'b0);
    exp_q = '{8'h57, 8'h0D, 8'h0A, 8'h60};
    exp_ack = '{1, 0};
    mptr = 1;
    drain("t3", 400); compare_stream("t3");

    // Busy never rises: fault after BT cycles, then normal service resumes
    clear_logs(); model_en = 1'b0;
    src_push(2, 8'h77, 1'b0);
    n = 0;
    while (sent_q.size() < 1 && n < 100) begin step(); n++; end
    s = (sent_q.size() > 0) ? send_cyc[0] : cyc;
    n = 0;
    while (tx_fault !== 1'b1 && n < 100) begin step(); n++; end
    check("t4_fault_delay", 32'(cyc - s), 32'(BT));
    n = 0;
    while (sched_busy !== 1'b0 && n < 100) begin step(); n++; end
    check("t4_back_idle", 32'(sched_busy), 32'd0);
    model_en = 1'b1;
    src_push(0, 8'h12, 1'b0);
    exp_q = '{8'h77, 8'h12};
    exp_ack = '{2, 0};
    mptr = 1;
    drain("t4", 400); compare_stream("t4");
    check("t4_fault_sticky", 32'(tx_fault), 32'd1);

    // One-cycle request while an external frame holds tx_busy
    ext_busy = 1'b1; step();
    na = ack_idx.size(); ns = sent_q.size();
    req[2] = 1'b1; req_data[23:16] = 8'h99;
    step();
    req[2] = 1'b0;
    repeat (5) step();
    check("t6_no_ack", 32'(ack_idx.size()), 32'(na));
    check("t6_no_send", 32'(sent_q.size()), 32'(ns));
    ext_busy = 1'b0; step();

    // Reset while waiting for busy to fall with CR LF pending
    clear_logs(); busy_len = 12;
    src_push(1, 8'h58, 1'b1);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin step(); n++; end
    repeat (3) step();
    check("t5_pre_busy", 32'(sched_busy), 32'd1);
    src_dat[1].delete(); src_eol[1].delete(); req = '0; req_eol = '0;
    reset = 1'b0;
    #1;
    check_reset_values("t5_rst");
    step();
    reset = 1'b1; mptr = 0;
    ns = sent_q.size();
    repeat (30) step();
    check("t5_no_term", 32'(sent_q.size()), 32'(ns));
    clear_logs();
    load(1, 8'h11, 1'b0); load(2, 8'h22, 1'b0);
    model_run(); drain("t5", 400); compare_stream("t5");

    // Randomized rounds against the round-robin model
    reset = 1'b0; step(); reset = 1'b1; mptr = 0;
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      busy_len = int'($urandom_range(1, 8));
      for (int i = 0; i < NREQ; i++) begin
        int k = int'($urandom_range(0, 3));
        for (int j = 0; j < k; j++)
          load(i, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      end
      model_run();
      drain($sformatf("rnd%0d", r), 2000);
      compare_stream($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
